// File: rtl/mem_buffer_arbiter.sv
// Round-robin arbiter between load/store (0) and fetch (1) requesters for one
// shared memory port, staging store and load data through an external buffer register.
module mem_buffer_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        sync_rst,
  input  logic                        clk_en,
  input  logic [1:0]                  req_valid,
  output logic [1:0]                  req_ready,
  input  logic [1:0]                  req_we,
  input  logic [2*MEM_ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0]     req_wdata,
  output logic [1:0]                  rsp_valid,
  output logic [DATA_WIDTH-1:0]       rsp_rdata,
  output logic                        buf_wr_en,
  output logic [DATA_WIDTH-1:0]       buf_data_in,
  output logic                        buf_rd_en,
  input  logic [DATA_WIDTH-1:0]       buf_data_out,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic                        mem_we,
  output logic [MEM_ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_wdata,
  input  logic                        mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DELIVER} state_t;

  state_t                      state_reg, state_next;
  logic                        ptr_reg, ptr_next;
  logic                        id_reg, id_next;
  logic                        we_reg, we_next;
  logic [MEM_ADDR_WIDTH-1:0]   addr_reg, addr_next;
  logic                        winner;
  logic                        active;

  logic [MEM_ADDR_WIDTH-1:0]   req_addr_arr  [2];
  logic [DATA_WIDTH-1:0]       req_wdata_arr [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
      assign req_addr_arr[gi]  = req_addr[gi*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
      assign req_wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Strobes and handshake sampling only happen on enabled, non-reset cycles.
  assign active = clk_en && !sync_rst;
  assign winner = (req_valid == 2'b11) ? ptr_reg : req_valid[1];

  assign mem_we    = we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = buf_data_out;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_reg <= IDLE;
      ptr_reg   <= 1'b0;
      id_reg    <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
    end else if (clk_en) begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      id_reg    <= id_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    id_next       = id_reg;
    we_next       = we_reg;
    addr_next     = addr_reg;
    req_ready     = 2'b00;
    rsp_valid     = 2'b00;
    rsp_rdata     = '0;
    buf_wr_en     = 1'b0;
    buf_data_in   = '0;
    buf_rd_en     = 1'b0;
    mem_req_valid = 1'b0;

    case (state_reg)
      IDLE: begin
        if (active && (req_valid != 2'b00)) begin
          req_ready  = winner ? 2'b10 : 2'b01;
          id_next    = winner;
          we_next    = req_we[winner];
          addr_next  = req_addr_arr[winner];
          ptr_next   = ~winner;
          state_next = ISSUE;
          // Store data lands in the buffer in the grant cycle, ready for issue.
          if (req_we[winner]) begin
            buf_wr_en   = 1'b1;
            buf_data_in = req_wdata_arr[winner];
          end
        end
      end
      ISSUE: begin
        mem_req_valid = !sync_rst;
        if (active && mem_req_ready)
          state_next = we_reg ? DELIVER : WAIT_RSP;
      end
      WAIT_RSP: begin
        if (active && mem_rsp_valid) begin
          buf_wr_en   = 1'b1;
          buf_data_in = mem_rdata;
          state_next  = DELIVER;
        end
      end
      DELIVER: begin
        if (active) begin
          rsp_valid  = id_reg ? 2'b10 : 2'b01;
          state_next = IDLE;
          if (!we_reg) begin
            buf_rd_en = 1'b1;
            rsp_rdata = buf_data_out;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/mem_buffer_arbiter.md
# mem_buffer_arbiter

- Two-requester round-robin controller for the shared memory buffer register; requester 0 is load/store, requester 1 is fetch.
- Grants one memory transaction at a time and stages data through the buffer: store data goes in before issue, load data comes back on response.
- Drives the buffer's write-enable, data-in and read-enable, plus a valid/ready request channel to memory.
- Returns a per-requester response pulse; one transaction is in flight at most.

## Interface
- DATA_WIDTH, 32, data word width
- MEM_ADDR_WIDTH, 32, memory address width
- clk  in  1  clock, rising edge
- sync_rst  in  1  synchronous reset, active-high
- clk_en  in  1  clock enable; low freezes all state
- req_valid  in  2  request valid, bit i = requester i
- req_ready  out  2  request accepted this cycle (one-hot or zero)
- req_we  in  2  1 = store, 0 = load, per requester
- req_addr  in  2×MEM_ADDR_WIDTH  address, requester i at slice i
- req_wdata  in  2×DATA_WIDTH  store data, requester i at slice i
- rsp_valid  out  2  one-cycle response/ack pulse to requester i
- rsp_rdata  out  DATA_WIDTH  load data, valid with rsp_valid; 0 for stores
- buf_wr_en  out  1  buffer write enable
- buf_data_in  out  DATA_WIDTH  buffer write data
- buf_rd_en  out  1  buffer read enable
- buf_data_out  in  DATA_WIDTH  buffer contents
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_we  out  1  memory write
- mem_addr  out  MEM_ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data; equals buf_data_out
- mem_rsp_valid  in  1  load response valid
- mem_rdata  in  DATA_WIDTH  load response data

## Operation
**States and transitions**
- IDLE: a grant is made when any req_valid bit is set and clk_en=1.
  - Winner: the only valid requester, or on contention the requester at the round-robin pointer.
  - req_ready is driven high for the winner only, combinationally.
  - The winner's we, addr and requester id are registered.
  - For a store, buf_wr_en=1 and buf_data_in=req_wdata of the winner in the same cycle.
  - The pointer moves to the non-winner.
  - Next state: ISSUE.
- ISSUE: mem_req_valid=1, with mem_we, mem_addr and mem_wdata held stable until mem_req_ready=1.
  - On acceptance, a store goes to DELIVER and a load goes to WAIT_RSP.
- WAIT_RSP: on mem_rsp_valid=1, buf_wr_en=1 and buf_data_in=mem_rdata; next state DELIVER.
- DELIVER: rsp_valid[id]=1 for one cycle; next state IDLE.
  - Load: buf_rd_en=1 and rsp_rdata=buf_data_out.
  - Store: buf_rd_en=0 and rsp_rdata=0.

**Gating and reset**
- mem_rsp_valid is ignored outside WAIT_RSP.
- req_valid is ignored outside IDLE; req_ready=0 there.
- With clk_en=0:
  - state, pointer and registered fields are frozen;
  - req_ready, buf_wr_en, buf_rd_en and rsp_valid are forced to 0;
  - mem_req_valid keeps its state-derived value;
  - mem_req_ready and mem_rsp_valid are not sampled. The memory side shares clk_en.
- sync_rst=1 takes priority over clk_en and aborts any state, including mid-transaction.
  - Reset values: state IDLE, pointer = requester 0.
  - All outputs 0, including buf_wr_en, buf_rd_en, mem_req_valid and rsp_valid.
  - No response is produced for an aborted transaction.

## Timing
- Accept at cycle N means mem_req_valid is first high at N+1.
- Store with an immediate memory accept: ack rsp_valid at N+2; earliest next grant at N+3.
- Load with accept at A and response at R (R ≥ A+1):
  - buffer is written at R;
  - rsp_valid and buf_rd_en are asserted at R+1;
  - earliest next grant at R+2.
- Minimum load-to-load spacing is 4 cycles.
- Each stalled cycle (mem_req_ready=0, or clk_en=0) adds exactly one cycle.

## Test plan
- Reset, then a single load from requester 0 at addr 0x100:
  - req_ready=2'b01 at N, mem_req_valid=1 at N+1 with mem_addr=0x100 and mem_we=0;
  - mem_rsp_valid with 0xDEADBEEF at N+3;
  - buf_rd_en=1, rsp_valid=2'b01 and rsp_rdata=0xDEADBEEF at N+4.
- Store from requester 1, data 0x12345678 to addr 0x40, mem_req_ready held 0 for 3 cycles:
  - buf_wr_en=1 at N;
  - mem_wdata=0x12345678 stable for 4 cycles;
  - rsp_valid=2'b10 one cycle after acceptance, with rsp_rdata=0.
- Both requesters valid continuously for 4 transactions: grants alternate 0,1,0,1 and no requester wins twice in a row.
- clk_en=0 for 2 cycles in WAIT_RSP while mem_rsp_valid pulses:
  - the pulse is ignored and state is unchanged;
  - a later mem_rsp_valid with clk_en=1 completes the load.
- sync_rst=1 during WAIT_RSP:
  - next cycle all outputs are 0 and state is IDLE;
  - the following mem_rsp_valid produces no rsp_valid;
  - the next contended grant goes to requester 0.
- Stray mem_rsp_valid in IDLE and ISSUE: no buf_wr_en, no rsp_valid.
